// File: rtl/clock_pkg.sv
// Shared constants for the panel clock design: 100 MHz cycle counts, repeat-FSM
// state encoding and the bit positions of the panel inputs.
package clock_pkg;

  localparam int DEF_DB_CYCLES    = 1_000_000;
  localparam int DEF_REPEAT_DELAY = 50_000_000;
  localparam int DEF_REPEAT_RATE  = 10_000_000;
  localparam logic [7:0] DEF_REPEAT_MASK = 8'b0000_1100;

  localparam int S1_IDX  = 0;
  localparam int S2_IDX  = 1;
  localparam int S3_IDX  = 2;
  localparam int S4_IDX  = 3;
  localparam int S5_IDX  = 4;
  localparam int S6_IDX  = 5;
  localparam int S7_IDX  = 6;
  localparam int PB1_IDX = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  // Width of a counter that must hold values 0..max_count-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int max_count);
    if (max_count > 1) return $clog2(max_count);
    return 1;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One input line: two-flop synchroniser, stable-count debouncer and registered
// press/release pulses that coincide with the first cycle of the new level.
module debounce_cell
  import clock_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level_out,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int DW = cnt_width(DB_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          s;

  assign s = sync_q[1];

  always_comb begin
    sync_d    = {sync_q[0], raw_in};
    cnt_d     = cnt_q;
    level_d   = level_q;
    // Any sample agreeing with the current level restarts the stability count.
    if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_LAST) begin
      level_d = s;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_out     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: rtl/input_conditioner.sv
// Panel input front end: per-line debounce cells plus an auto-repeat FSM on the
// lines selected by REPEAT_MASK; unselected lines repeat only their press pulse.
module input_conditioner
  import clock_pkg::*;
#(
  parameter int N_IN         = 8,
  parameter int DB_CYCLES    = DEF_DB_CYCLES,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter logic [N_IN-1:0] REPEAT_MASK = DEF_REPEAT_MASK
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] raw_in,
  output logic [N_IN-1:0] level_out,
  output logic [N_IN-1:0] press_pulse,
  output logic [N_IN-1:0] release_pulse,
  output logic [N_IN-1:0] repeat_pulse
);

  localparam int RW = cnt_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);

  for (genvar i = 0; i < N_IN; i++) begin : g_line

    debounce_cell #(
      .DB_CYCLES(DB_CYCLES)
    ) u_cell (
      .clk          (clk),
      .rst          (rst),
      .raw_in       (raw_in[i]),
      .level_out    (level_out[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i])
    );

    if (REPEAT_MASK[i]) begin : g_rpt
      rpt_state_e    state_q, state_d;
      logic [RW-1:0] cnt_q, cnt_d;
      logic          rpt_d;

      // A released line always wins over a due repeat, so no pulse trails the release.
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rpt_d   = 1'b0;
        case (state_q)
          IDLE: begin
            if (press_pulse[i]) begin
              rpt_d   = 1'b1;
              cnt_d   = '0;
              state_d = DELAY;
            end
          end
          DELAY: begin
            if (!level_out[i]) begin
              cnt_d   = '0;
              state_d = IDLE;
            end else if (cnt_q == RD_LAST) begin
              rpt_d   = 1'b1;
              cnt_d   = '0;
              state_d = REPEAT;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          REPEAT: begin
            if (!level_out[i]) begin
              cnt_d   = '0;
              state_d = IDLE;
            end else if (cnt_q == RR_LAST) begin
              rpt_d = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        endcase
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      assign repeat_pulse[i] = rpt_d;
    end else begin : g_direct
      assign repeat_pulse[i] = press_pulse[i];
    end

  end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with short debounce/repeat counts:
// expected pulses are queued when a pin is driven and matched every cycle.
module tb_input_conditioner;

  localparam int N_IN = 8;
  localparam int DB   = 4;
  localparam int RD   = 10;
  localparam int RR   = 3;
  localparam logic [7:0] MASK = 8'b0000_1100;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_IN-1:0] raw_in;
  logic [N_IN-1:0] level_out;
  logic [N_IN-1:0] press_pulse;
  logic [N_IN-1:0] release_pulse;
  logic [N_IN-1:0] repeat_pulse;

  typedef struct {
    int at;
    int kind;
    int bitn;
  } exp_t;

  exp_t       sb[$];
  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] lvl_exp;
  logic [7:0] ep, er, et;

  input_conditioner #(
    .N_IN        (N_IN),
    .DB_CYCLES   (DB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR),
    .REPEAT_MASK (MASK)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .raw_in       (raw_in),
    .level_out    (level_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input int at, input int kind, input int bitn);
    exp_t e;
    e.at = at;
    e.kind = kind;
    e.bitn = bitn;
    sb.push_back(e);
  endtask

  // Model of one line: press at press_at, level high until end_at, repeats on masked lines.
  task automatic expect_line(input int bitn, input int press_at, input int end_at, input bit has_rel);
    logic [7:0] m;
    int t;
    m = MASK;
    push_exp(press_at, 0, bitn);
    push_exp(press_at, 2, bitn);
    if (m[bitn]) begin
      t = press_at + RD;
      while (t < end_at) begin
        push_exp(t, 2, bitn);
        t += RR;
      end
    end
    if (has_rel) push_exp(end_at, 1, bitn);
  endtask

  // Advance to the next falling edge and gather the pulses due in this cycle.
  task automatic adv();
    @(negedge clk);
    ep = '0;
    er = '0;
    et = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        case (sb[i].kind)
          0:       ep[sb[i].bitn] = 1'b1;
          1:       er[sb[i].bitn] = 1'b1;
          default: et[sb[i].bitn] = 1'b1;
        endcase
        sb.delete(i);
      end
    end
    lvl_exp = (lvl_exp | ep) & ~er;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      if (i == 3) rst = 1'b1;
      adv();
      checks++;
      if ({level_out, press_pulse, release_pulse, repeat_pulse} !== {lvl_exp, ep, er, et}) begin
        errors++;
        $display("[TB] FAIL test_reset cyc=%0d got lvl=%b prs=%b rel=%b rpt=%b expected lvl=%b prs=%b rel=%b rpt=%b",
                 cyc, level_out, press_pulse, release_pulse, repeat_pulse, lvl_exp, ep, er, et);
      end
    end
  endtask

  task automatic test_press_release();
    int k;
    k = cyc;
    for (int i = 0; i < 24; i++) begin
      if (i == 0) begin
        raw_in[0] = 1'b1;
        expect_line(0, k + DB + 2, k + 12 + DB + 2, 1'b1);
      end
      if (i == 12) raw_in[0] = 1'b0;
      adv();
      checks++;
      if ({level_out, press_pulse, release_pulse, repeat_pulse} !== {lvl_exp, ep, er, et}) begin
        errors++;
        $display("[TB] FAIL test_press_release cyc=%0d got lvl=%b prs=%b rel=%b rpt=%b expected lvl=%b prs=%b rel=%b rpt=%b",
                 cyc, level_out, press_pulse, release_pulse, repeat_pulse, lvl_exp, ep, er, et);
      end
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 22; i++) begin
      if (i == 0) raw_in[1] = 1'b1;
      if (i == 3) raw_in[1] = 1'b0;
      if (i >= 4 && i < 14) raw_in[1] = (i % 2 == 0);
      if (i == 14) raw_in[1] = 1'b0;
      adv();
      checks++;
      if ({level_out, press_pulse, release_pulse, repeat_pulse} !== {lvl_exp, ep, er, et}) begin
        errors++;
        $display("[TB] FAIL test_bounce cyc=%0d got lvl=%b prs=%b rel=%b rpt=%b expected lvl=%b prs=%b rel=%b rpt=%b",
                 cyc, level_out, press_pulse, release_pulse, repeat_pulse, lvl_exp, ep, er, et);
      end
    end
  endtask

  task automatic test_hold(input int bitn);
    int k;
    k = cyc;
    for (int i = 0; i < 42; i++) begin
      if (i == 0) begin
        raw_in[bitn] = 1'b1;
        expect_line(bitn, k + DB + 2, k + 30 + DB + 2, 1'b1);
      end
      if (i == 30) raw_in[bitn] = 1'b0;
      adv();
      checks++;
      if ({level_out, press_pulse, release_pulse, repeat_pulse} !== {lvl_exp, ep, er, et}) begin
        errors++;
        $display("[TB] FAIL test_hold bit%0d cyc=%0d got lvl=%b prs=%b rel=%b rpt=%b expected lvl=%b prs=%b rel=%b rpt=%b",
                 bitn, cyc, level_out, press_pulse, release_pulse, repeat_pulse, lvl_exp, ep, er, et);
      end
    end
  endtask

  task automatic test_simultaneous();
    int k;
    k = cyc;
    for (int i = 0; i < 24; i++) begin
      if (i == 0) begin
        raw_in[3:2] = 2'b11;
        expect_line(2, k + DB + 2, k + 12 + DB + 2, 1'b1);
        expect_line(3, k + DB + 2, k + 12 + DB + 2, 1'b1);
      end
      if (i == 12) raw_in[3:2] = 2'b00;
      adv();
      checks++;
      if ({level_out, press_pulse, release_pulse, repeat_pulse} !== {lvl_exp, ep, er, et}) begin
        errors++;
        $display("[TB] FAIL test_simultaneous cyc=%0d got lvl=%b prs=%b rel=%b rpt=%b expected lvl=%b prs=%b rel=%b rpt=%b",
                 cyc, level_out, press_pulse, release_pulse, repeat_pulse, lvl_exp, ep, er, et);
      end
    end
  endtask

  task automatic test_reset_mid_repeat();
    int k;
    int r;
    k = cyc;
    r = 0;
    for (int i = 0; i < 54; i++) begin
      if (i == 0) begin
        raw_in[3] = 1'b1;
        expect_line(3, k + DB + 2, k + 20, 1'b0);
      end
      if (i == 20) begin
        rst = 1'b0;
        #1;
        checks++;
        if ({level_out, press_pulse, release_pulse, repeat_pulse} !== 32'h0) begin
          errors++;
          $display("[TB] FAIL test_reset_mid_repeat async clear got lvl=%b prs=%b rel=%b rpt=%b expected all zero",
                   level_out, press_pulse, release_pulse, repeat_pulse);
        end
        sb.delete();
        lvl_exp = '0;
      end
      if (i == 23) begin
        rst = 1'b1;
        r = cyc;
        expect_line(3, r + DB + 2, r + 20 + DB + 2, 1'b1);
      end
      if (i == 43) raw_in[3] = 1'b0;
      adv();
      checks++;
      if ({level_out, press_pulse, release_pulse, repeat_pulse} !== {lvl_exp, ep, er, et}) begin
        errors++;
        $display("[TB] FAIL test_reset_mid_repeat cyc=%0d got lvl=%b prs=%b rel=%b rpt=%b expected lvl=%b prs=%b rel=%b rpt=%b",
                 cyc, level_out, press_pulse, release_pulse, repeat_pulse, lvl_exp, ep, er, et);
      end
    end
  endtask

  initial begin
    rst     = 1'b0;
    raw_in  = '0;
    lvl_exp = '0;
    ep      = '0;
    er      = '0;
    et      = '0;
    test_reset();
    test_press_release();
    test_bounce();
    test_hold(2);
    test_hold(0);
    test_simultaneous();
    test_reset_mid_repeat();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d pending entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
